// File: rtl/ps2_frame_receiver_pkg.sv
// ps2_pkg: shared receive-FSM state type and PS/2 frame constants.
package ps2_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_rx_state_t;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_frame_receiver_if.sv
// ps2_frame_receiver_if: raw PS/2 pins in, decoded key events out.
interface ps2_frame_receiver_if;
    logic PS2_clock;
    logic PS2_data;
    logic [7:0] PS2_code;
    logic PS2_code_ready;
    logic PS2_make_code;
    logic PS2_extended;
    logic PS2_error;
    modport master (output PS2_clock, PS2_data,
                    input PS2_code, PS2_code_ready, PS2_make_code, PS2_extended, PS2_error);
    modport slave (input PS2_clock, PS2_data,
                   output PS2_code, PS2_code_ready, PS2_make_code, PS2_extended, PS2_error);
endinterface

// File: rtl/ps2_frame_receiver_clock_filter.sv
// ps2_clock_filter: synchronises the PS/2 pins, debounces the clock and strobes its falling edge.
module ps2_clock_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);
    localparam int unsigned CW = $clog2(FILTER_LEN) + 1;
    logic [1:0] clk_sync_q, data_sync_q;
    logic filt_q, filt_d, fall_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic diff, done;
    assign diff = clk_sync_q[1] != filt_q;
    assign done = cnt_q == CW'(FILTER_LEN - 1);
    always_comb begin
        cnt_d = (!diff || done) ? '0 : cnt_q + CW'(1);
        filt_d = (diff && done) ? clk_sync_q[1] : filt_q;
    end
    // Synchronisers idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q <= filt_d;
            cnt_q <= cnt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end
    assign fall_o = fall_q;
    assign data_o = data_sync_q[1];
endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: deserialises PS/2 frames and folds F0/E0 prefixes into make/extended flags.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_COUNT = 50000
) (
    input logic Clock_50,
    input logic Reset,
    ps2_frame_receiver_if.slave ps2
);
    localparam int unsigned TW = $clog2(TIMEOUT_COUNT + 1);
    ps2_rx_state_t state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, code_q, code_d;
    logic par_q, par_d, brk_q, brk_d, ext_q, ext_d;
    logic make_q, make_d, exto_q, exto_d, ready_q, ready_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic fall, data, good, tmo_hit;
    ps2_clock_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk(Clock_50), .rst(Reset), .ps2_clk_i(ps2.PS2_clock), .ps2_data_i(ps2.PS2_data),
        .fall_o(fall), .data_o(data)
    );
    assign good = data & (^{shift_q, par_q});
    assign tmo_hit = tmo_q == TW'(TIMEOUT_COUNT - 1);
    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        par_d = par_q;
        brk_d = brk_q;
        ext_d = ext_q;
        code_d = code_q;
        make_d = make_q;
        exto_d = exto_q;
        ready_d = 1'b0;
        err_d = 1'b0;
        tmo_d = (state_q == S_IDLE || fall) ? '0 : (tmo_hit ? tmo_q : tmo_q + TW'(1));
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    state_d = data ? S_IDLE : S_DATA;
                    bit_d = '0;
                    err_d = data;
                end
                S_DATA: begin
                    shift_d = {data, shift_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? S_PARITY : S_DATA;
                end
                S_PARITY: begin
                    par_d = data;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (!good) begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else if (shift_q == PS2_BREAK_PREFIX) begin
                        brk_d = 1'b1;
                    end else if (shift_q == PS2_EXT_PREFIX) begin
                        ext_d = 1'b1;
                    end else begin
                        code_d = shift_q;
                        make_d = ~brk_q;
                        exto_d = ext_q;
                        ready_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
            endcase
        end else if (state_q != S_IDLE && tmo_hit) begin
            state_d = S_IDLE;
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
        end
    end
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            bit_q <= '0;
            shift_q <= '0;
            par_q <= 1'b0;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
            code_q <= '0;
            make_q <= 1'b0;
            exto_q <= 1'b0;
            ready_q <= 1'b0;
            err_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            par_q <= par_d;
            brk_q <= brk_d;
            ext_q <= ext_d;
            code_q <= code_d;
            make_q <= make_d;
            exto_q <= exto_d;
            ready_q <= ready_d;
            err_q <= err_d;
            tmo_q <= tmo_d;
        end
    end
    assign ps2.PS2_code = code_q;
    assign ps2.PS2_code_ready = ready_q;
    assign ps2.PS2_make_code = make_q;
    assign ps2.PS2_extended = exto_q;
    assign ps2.PS2_error = err_q;
endmodule

// File: doc/ps2_frame_receiver.md
# ps2_frame_receiver

Serial receive front end for the PS/2 keyboard path. It synchronises and filters the raw `PS2_CLOCK_I`/`PS2_DATA_I` pins and deserialises 11-bit frames. It checks the start, parity and stop bits and folds the `F0` (break) and `E0` (extended) prefixes into flags. It presents one code per key event to the keyboard-to-LCD top level through `PS2_code` / `PS2_code_ready` / `PS2_make_code`.

## Interface
- `FILTER_LEN`, default 8: consecutive equal synchronised samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_COUNT`, default 50000: system cycles without a filtered falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).
- `Clock_50  input  1`: system clock, 50 MHz; the only clock.
- `Reset  input  1`: asynchronous, active-high reset.
- `PS2_clock  input  1`: raw PS/2 clock pin, asynchronous.
- `PS2_data  input  1`: raw PS/2 data pin, asynchronous.
- `PS2_code  output  8`: last delivered scan code, held until the next delivery.
- `PS2_code_ready  output  1`: one-cycle pulse when `PS2_code` and the flags update.
- `PS2_make_code  output  1`: 1 = make, 0 = break (code was preceded by `F0`); held with `PS2_code`.
- `PS2_extended  output  1`: code was preceded by `E0`; held with `PS2_code`.
- `PS2_error  output  1`: one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- **Sampling:** both pins go through a 2-FF synchroniser. The filtered clock starts at 1 and takes a new level only after `FILTER_LEN` consecutive equal samples. A filtered 1->0 transition produces a single-cycle `fall` strobe. Data is sampled from the synchronised data line on `fall`.
- **FSM states:** `S_IDLE`, `S_DATA`, `S_PARITY`, `S_STOP`. Transitions occur only on `fall`, except for the timeout.
  - `S_IDLE`: data = 0 (start bit) goes to `S_DATA` with bit count 0. Data = 1 stays in `S_IDLE` and pulses `PS2_error`.
  - `S_DATA`: shift the data bit into the byte LSB first. After the 8th bit, go to `S_PARITY`.
  - `S_PARITY`: capture the parity bit and go to `S_STOP`.
  - `S_STOP`: the frame is good when the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Always return to `S_IDLE`.
- **Good frame:**
  - byte `8'hF0`: set `break_pending`; no `PS2_code_ready`.
  - byte `8'hE0`: set `ext_pending`; no `PS2_code_ready`.
  - any other byte: `PS2_code` <= byte, `PS2_make_code` <= ~`break_pending`, `PS2_extended` <= `ext_pending`; pulse `PS2_code_ready`; clear both pending flags.
- **Bad frame:** pulse `PS2_error`, discard the byte, clear both pending flags. The held outputs do not change.
- **Timeout:** a cycle counter runs while not in `S_IDLE` and clears on each `fall`. When it reaches `TIMEOUT_COUNT - 1`, go to `S_IDLE`, pulse `PS2_error` and clear both pending flags. The counter saturates and does not wrap.
- **Repeated prefixes:** `F0 F0` or `E0 E0` leave the flag set; no error.

## Timing
- **Reset values:** `PS2_code` = 8'h00; `PS2_code_ready`, `PS2_make_code`, `PS2_extended` and `PS2_error` all 0. FSM in `S_IDLE`, filtered clock = 1, both pending flags 0, counters 0.
- **Delivery latency:** `PS2_code_ready` and the updated outputs appear on the clock edge after the `fall` that samples the stop bit. From the pin falling edge this is 2 + `FILTER_LEN` + 1 cycles.
- **`PS2_code_ready`:** high for exactly one cycle. It never asserts on the same cycle as `PS2_error`.
- **Reset mid-frame:** the partial frame and the pending flags are lost, and all outputs return to their reset values immediately.
- **Consumer:** none required. The consumer edge-detects `PS2_code_ready`; there is no back-pressure.

## Structure
- **Package `ps2_pkg`:** the state enum `ps2_rx_state_t`, the constants `PS2_BREAK_PREFIX` = 8'hF0 and `PS2_EXT_PREFIX` = 8'hE0, and the frame length constant 11.
- **Sub-module `ps2_clock_filter`:** contains the synchroniser, the `FILTER_LEN` filter and the `fall` strobe, with synchronised data passed through. It is reused by any future PS/2 transmit path.

## Test plan
- **Make code:** frame `1C` (parity 0, stop 1) -> one `PS2_code_ready` pulse; `PS2_code` = 8'h1C, `PS2_make_code` = 1, `PS2_extended` = 0.
- **Break sequence:** `F0` (parity 1) then `1C` -> no pulse after `F0`; one pulse after `1C` with `PS2_make_code` = 0; `PS2_code` = 8'h1C.
- **Extended break:** `E0`, `F0`, `75` -> exactly one pulse; `PS2_code` = 8'h75, `PS2_extended` = 1, `PS2_make_code` = 0. A following plain `75` gives `PS2_extended` = 0, `PS2_make_code` = 1.
- **Parity error:** `1C` sent with parity 1 -> `PS2_error` pulse, no ready, `PS2_code` unchanged; the next good frame `32` is delivered normally.
- **Timeout:** stop the PS/2 clock after 4 data bits for `TIMEOUT_COUNT` cycles -> `PS2_error` pulse and FSM back in `S_IDLE`; the next full `1C` frame is delivered.
- **Glitch and reset:**
  - 3-cycle low glitch on `PS2_clock` with `FILTER_LEN` = 8 -> no `fall`, no state change.
  - Assert `Reset` during bit 5 -> all outputs reset immediately, and the next full `1C` frame is delivered normally.
